reaction_timer_core: RTL
========================

Name: reaction_timer_core

Overview:
- Downstream consumer of the one-millisecond tick generator: the reaction-time game core.
- On start, waits a pseudo-random delay counted in ms ticks, lights the GO LED, then counts elapsed milliseconds in BCD until the player presses stop.
- The BCD result drives the 7-segment display multiplexer.
- Pressing stop before GO is reported as a false start.

Parameters:
- DIGITS, 4, number of BCD display digits; count range 0 to 10^DIGITS-1.
- MIN_DELAY_MS, 1000, minimum random wait in ms ticks.
- RAND_BITS, 11, number of LFSR bits added to MIN_DELAY_MS; random span 0 to 2^RAND_BITS-1.
- LFSR_SEED, 12'hACE, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, same clock as the tick generator.
- rst  in  1  synchronous, active-high reset.
- oneMilliSecond  in  1  one-cycle tick from the 1 ms timer.
- startBtn  in  1  debounced single-cycle start pulse.
- stopBtn  in  1  debounced single-cycle stop pulse.
- ledGo  out  1  high while in RUN.
- bcdCount  out  4*DIGITS  elapsed ms in BCD; digit 0 is bits [3:0].
- done  out  1  high in DONE (valid result held).
- falseStart  out  1  high in FALSE_START.
- overflow  out  1  sticky; set when the count saturates, cleared on the next start.

Behaviour:
- Reset is synchronous, active-high, single clock. On reset: state=IDLE, all outputs 0, delay counter 0, LFSR=LFSR_SEED. Reset mid-round aborts immediately.
- LFSR: 12-bit Fibonacci, taps 12,11,10,4. It advances every clk cycle regardless of state, so button timing supplies entropy.
- All outputs are registered. A state change and its outputs become visible one cycle after the causing input.
- IDLE:
  - startBtn -> DELAY.
  - Load delayCnt = MIN_DELAY_MS + LFSR[RAND_BITS-1:0], clear bcdCount and overflow.
  - stopBtn ignored.
- DELAY:
  - Each tick decrements delayCnt.
  - Tick while delayCnt==1 -> RUN (delay is exactly delayCnt ticks).
  - stopBtn -> FALSE_START. stopBtn wins over a same-cycle transitioning tick.
  - startBtn ignored.
- RUN:
  - Each tick increments bcdCount by 1 with decimal carry; digit 9 rolls to 0 and carries.
  - Tick at all-9s: hold all-9s, set overflow, -> DONE.
  - stopBtn -> DONE. If stopBtn and tick arrive in the same cycle, the tick is not counted.
  - startBtn ignored.
- DONE: bcdCount held. startBtn -> DELAY (new round, same loading as from IDLE).
- FALSE_START: bcdCount=0. startBtn -> DELAY.
- startBtn and stopBtn in the same cycle: stop has priority in DELAY/RUN; start has priority in IDLE/DONE/FALSE_START.
- Tick level is never latched. Ticks are counted only in the cycle they are high.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- When defined:
  - Adds output bestCount (4*DIGITS), reset to all-9s.
  - On each entry into DONE without overflow, bestCount <= min(bestCount, bcdCount), compared digit-wise from the MSD.
  - Adds output newBest, a one-cycle pulse when bestCount updates.
- When undefined: no ports, registers or logic for best time.

Decomposition:
- Package reaction_pkg holds:
  - state enum {IDLE, DELAY, RUN, DONE, FALSE_START};
  - BCD digit typedef (4 bits);
  - LFSR tap constant and LFSR width (12).
- Sub-module bcd_counter: DIGITS-digit saturating BCD incrementer.
  - Inputs: clr, inc.
  - Outputs: count, sat.
  - Instantiated once in the core.

Test Plan:
- Reset then startBtn with LFSR forced to seed 12'hACE -> DELAY for 1000+(12'hACE&11'h7FF) = 1000+718 = 1718 ticks before ledGo=1; no early GO.
- In RUN, drive 237 ticks then stopBtn -> done=1, bcdCount=16'h0237, ledGo=0.
- stopBtn 5 ticks into DELAY -> falseStart=1, bcdCount=0, ledGo never asserted; startBtn -> DELAY again, falseStart=0.
- In RUN, 10000 ticks -> bcdCount=16'h9999, overflow=1, done=1; next startBtn clears overflow.
- In RUN at count 41, stopBtn and tick in same cycle -> bcdCount=16'h0041.
- rst mid-RUN at count 500 -> next cycle all outputs 0, state IDLE. With REACTION_BEST_TIME_EN: rounds of 300 then 250 -> bestCount=16'h0250, newBest pulsed twice.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game core.
package reaction_pkg;

    localparam int LFSR_W = 12;
    // Taps 12,11,10,4 expressed as a bit mask over lfsr[11:0].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'hE08;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RUN,
        DONE,
        FALSE_START
    } state_e;

endpackage

// File: rtl/bcd_counter.sv
// DIGITS-digit BCD incrementer that holds at all-9s; sat flags the held value.
module bcd_counter
    import reaction_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] count,
    output logic                sat
);

    bcd_digit_t [DIGITS-1:0] cnt_d, cnt_q;
    logic                    carry;

    assign sat   = (cnt_q == {DIGITS{4'h9}});
    assign count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        carry = inc && !sat;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[i] == 4'd9) begin
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game: random ms delay, GO LED, BCD ms count until stop.
// Optional best-time tracking is enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int                DIGITS       = 4,
    parameter int                MIN_DELAY_MS = 1000,
    parameter int                RAND_BITS    = 11,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 12'hACE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                oneMilliSecond,
    input  logic                startBtn,
    input  logic                stopBtn,
    output logic                ledGo,
    output logic [4*DIGITS-1:0] bcdCount,
    output logic                done,
    output logic                falseStart,
`ifdef REACTION_BEST_TIME_EN
    output logic [4*DIGITS-1:0] bestCount,
    output logic                newBest,
`endif
    output logic                overflow
);

    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    state_e            state_d, state_q;
    logic [DLY_W-1:0]  delay_d, delay_q;
    logic [LFSR_W-1:0] lfsr_d, lfsr_q;
    logic              ovf_d, ovf_q;
    logic              led_q, done_q, fs_q;
    logic              cnt_clr, cnt_inc, cnt_sat;
    logic [4*DIGITS-1:0] cnt;

    assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        ovf_d   = ovf_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE, DONE, FALSE_START: begin
                if (startBtn) begin
                    state_d = DELAY;
                    delay_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
                    ovf_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            DELAY: begin
                if (stopBtn) begin
                    state_d = FALSE_START;
                    cnt_clr = 1'b1;
                end else if (oneMilliSecond) begin
                    delay_d = delay_q - DLY_W'(1);
                    if (delay_q == DLY_W'(1)) state_d = RUN;
                end
            end
            RUN: begin
                // A tick coincident with stop is dropped.
                if (stopBtn) begin
                    state_d = DONE;
                end else if (oneMilliSecond) begin
                    if (cnt_sat) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            delay_q <= '0;
            lfsr_q  <= LFSR_SEED;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            lfsr_q  <= lfsr_d;
            ovf_q   <= ovf_d;
            led_q   <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            fs_q    <= (state_d == FALSE_START);
        end
    end

    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(cnt),
        .sat  (cnt_sat)
    );

    assign ledGo      = led_q;
    assign done       = done_q;
    assign falseStart = fs_q;
    assign overflow   = ovf_q;
    assign bcdCount   = cnt;

`ifdef REACTION_BEST_TIME_EN
    logic [4*DIGITS-1:0] best_d, best_q;
    logic                new_best_d, new_best_q;

    // Packed BCD compares correctly as unsigned binary, MSD first.
    always_comb begin
        best_d     = best_q;
        new_best_d = 1'b0;
        if (state_q == RUN && state_d == DONE && !ovf_d && cnt < best_q) begin
            best_d     = cnt;
            new_best_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q     <= {DIGITS{4'h9}};
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign bestCount = best_q;
    assign newBest   = new_best_q;
`endif

endmodule
